simd_vec_alu_pipe: RTL and testbench
====================================

// Module: simd_vec_alu_pipe
// PURPOSE
//  Pipelined, parametrised SIMD vector ALU for the AES datapath: NWORDS x 32-bit words, each split into 4 byte lanes.
//  Executes lane-wise byte ops and per-word AES MixColumns on a valid/ready stream.
//  Sits between the vector register file read stage and the writeback stage.
//  Replaces the single-word combinational unit with a 2-stage registered pipeline that supports backpressure.
// PARAMETERS
//  NWORDS   4   number of 32-bit words per vector; must be >=1 (data width = 32*NWORDS)
// PORTS
//  clk        in   1          clock; all state updates on the rising edge
//  rst_n      in   1          reset, asynchronous assert, active-low
//  in_valid   in   1          operand beat valid
//  in_ready   out  1          unit can accept a beat this cycle
//  in_a       in   32*NWORDS  operand A
//  in_b       in   32*NWORDS  operand B (ignored by MixColumns ops)
//  in_op      in   3          opcode, see BEHAVIOUR
//  out_valid  out  1          result beat valid
//  out_ready  in   1          consumer accepts the result
//  out_res    out  32*NWORDS  result
//  out_err    out  1          beat carried an illegal opcode
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_res=0, out_err=0.
//    in_ready=1 as soon as reset deasserts. Reset mid-operation discards all in-flight beats.
//  - Handshakes:
//    - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
//    - out_* hold stable while out_valid & !out_ready.
//  - Pipeline:
//    - S1 registers a, b and op. S2 registers out_res and out_err, computed from the S1 contents.
//    - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational, no skid buffer).
//    - Latency is 2 cycles from input transfer to out_valid. Throughput is 1 beat/cycle when out_ready is held at 1.
//    - Beats are never dropped, duplicated or reordered under any out_ready pattern.
//    - When in_valid=0, a bubble propagates and out_valid falls accordingly.
//  - Opcodes, lane-wise on every byte unless noted:
//    - 000 XOR.
//    - 001 ADD mod 256, no carry between lanes.
//    - 010 SUB mod 256, borrow discarded.
//    - 011 AND.
//    - 100 OR.
//    - 101 MixColumns on each 32-bit word.
//    - 110 InvMixColumns (see CONFIGURATION).
//    - 111 and disabled opcodes: illegal.
//  - Column byte order per word w (fixed): input s0=w[31:24], s1=w[23:16], s2=w[15:8], s3=w[7:0].
//    Output r0->[7:0], r1->[15:8], r2->[23:16], r3->[31:24].
//  - GF(2^8) arithmetic uses polynomial 0x11B; xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
//  - Illegal opcode: out_res=0 and out_err=1 for that beat only. The pipeline keeps flowing; no sticky state.
//  - With NWORDS=1 the block is functionally the 32-bit single-word unit plus the pipeline.
// CONFIGURATION
//  - Macro SIMD_INV_MIXCOL_EN:
//    - Defined: op 110 computes InvMixColumns (coefficients 0e 0b 0d 09) using the same byte order as MixColumns.
//    - Not defined: the InvMixColumns logic is not built, and op 110 is illegal (out_res=0, out_err=1).
// STRUCTURE
//  - Package simd_alu_pkg:
//    - typedef enum logic [2:0] simd_op_e {OP_XOR, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MIXCOL, OP_INVMIXCOL, OP_ILLEGAL}.
//    - localparam LANE_W=8, WORD_W=32, GF_POLY=8'h1B.
//    - Functions xtime() and gf_mul8().
//  - Sub-module gf_mixcol_word: combinational, one 32-bit word, input inv selects the inverse coefficient matrix.
//    - Instantiated NWORDS times via generate in the S2 compute path.
//    - The inverse branch is guarded by SIMD_INV_MIXCOL_EN.
// TESTING
//  1. NWORDS=4, op=001, a={16{8'hFF}}, b={16{8'h01}}, out_ready=1.
//     -> out_res=0 exactly 2 cycles later, out_err=0 (no inter-lane carry).
//  2. op=101, every word 32'hDB135345 -> every word 32'hBCA14D8E.
//     Also word 32'h01010101 -> 32'h01010101.
//  3. Macro defined: op=110, word 32'h8E4DA1BC -> 32'h455313DB.
//     Macro undefined: same stimulus -> out_res=0, out_err=1.
//  4. Backpressure: stream 8 XOR beats (a=i, b=8'hA5 replicated) with out_ready toggling 1,0,0,1,...
//     -> all 8 results arrive in order and are correct; in_ready=0 only while both stages are full and out_ready=0.
//  5. op=111 between two legal beats -> only the middle beat has out_err=1 and out_res=0; neighbours unaffected.
//  6. Deassert rst_n with 2 beats in flight -> out_valid=0 immediately (async).
//     After release, the next beat emerges 2 cycles after acceptance with no stale data.

Source files
------------

// File: rtl/simd_alu_pkg.sv
// Shared types, widths and GF(2^8) helpers for the SIMD vector ALU.
package simd_alu_pkg;

    typedef enum logic [2:0] {
        OP_XOR       = 3'b000,
        OP_ADD       = 3'b001,
        OP_SUB       = 3'b010,
        OP_AND       = 3'b011,
        OP_OR        = 3'b100,
        OP_MIXCOL    = 3'b101,
        OP_INVMIXCOL = 3'b110,
        OP_ILLEGAL   = 3'b111
    } simd_op_e;

    localparam int         LANE_W  = 8;
    localparam int         WORD_W  = 32;
    localparam logic [7:0] GF_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply; only ever called with constant coefficients.
    function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_mixcol_word.sv
// Combinational AES (Inv)MixColumns on one 32-bit column.
// The inverse matrix is only built when SIMD_INV_MIXCOL_EN is defined.
module gf_mixcol_word
    import simd_alu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic              inv,
    output logic [WORD_W-1:0] res
);

    logic [7:0]        s0, s1, s2, s3;
    logic [WORD_W-1:0] fwd;

    // Input column is big-endian in the word, result column little-endian.
    assign s0 = word[31:24];
    assign s1 = word[23:16];
    assign s2 = word[15:8];
    assign s3 = word[7:0];

    assign fwd[7:0]   = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
    assign fwd[15:8]  = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
    assign fwd[23:16] = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
    assign fwd[31:24] = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);

`ifdef SIMD_INV_MIXCOL_EN
    logic [WORD_W-1:0] bwd;

    assign bwd[7:0]   = gf_mul8(s0, 8'h0E) ^ gf_mul8(s1, 8'h0B) ^ gf_mul8(s2, 8'h0D) ^ gf_mul8(s3, 8'h09);
    assign bwd[15:8]  = gf_mul8(s0, 8'h09) ^ gf_mul8(s1, 8'h0E) ^ gf_mul8(s2, 8'h0B) ^ gf_mul8(s3, 8'h0D);
    assign bwd[23:16] = gf_mul8(s0, 8'h0D) ^ gf_mul8(s1, 8'h09) ^ gf_mul8(s2, 8'h0E) ^ gf_mul8(s3, 8'h0B);
    assign bwd[31:24] = gf_mul8(s0, 8'h0B) ^ gf_mul8(s1, 8'h0D) ^ gf_mul8(s2, 8'h09) ^ gf_mul8(s3, 8'h0E);

    assign res = inv ? bwd : fwd;
`else
    assign res = inv ? '0 : fwd;
`endif

endmodule

// File: rtl/simd_vec_alu_pipe.sv
// Two-stage valid/ready SIMD byte-lane ALU with per-word AES MixColumns.
// Define SIMD_INV_MIXCOL_EN to enable opcode 110 (InvMixColumns); otherwise it is illegal.
module simd_vec_alu_pipe
    import simd_alu_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] in_a,
    input  logic [WORD_W*NWORDS-1:0] in_b,
    input  logic [2:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] out_res,
    output logic                     out_err
);

    localparam int W      = WORD_W * NWORDS;
    localparam int NLANES = W / LANE_W;

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    simd_op_e     s1_op;
    logic         s2_valid;
    logic         adv1;
    logic         adv2;
    logic [W-1:0] mix_res;
    logic [W-1:0] res_next;
    logic         err_next;

    // A stage may load when it is empty or its contents move on this edge.
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_XOR;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= simd_op_e'(in_op);
            end
        end
    end

    for (genvar w = 0; w < NWORDS; w++) begin : g_mix
        gf_mixcol_word u_mix (
            .word (s1_a[w*WORD_W +: WORD_W]),
            .inv  (s1_op == OP_INVMIXCOL),
            .res  (mix_res[w*WORD_W +: WORD_W])
        );
    end

    // NOTE: defaults at the top of always_comb keep every path assigned, so no latch is inferred.
    always_comb begin
        res_next = '0;
        err_next = 1'b0;
        case (s1_op)
            OP_XOR: res_next = s1_a ^ s1_b;
            OP_ADD: begin
                for (int i = 0; i < NLANES; i++)
                    res_next[i*LANE_W +: LANE_W] = s1_a[i*LANE_W +: LANE_W] + s1_b[i*LANE_W +: LANE_W];
            end
            OP_SUB: begin
                for (int i = 0; i < NLANES; i++)
                    res_next[i*LANE_W +: LANE_W] = s1_a[i*LANE_W +: LANE_W] - s1_b[i*LANE_W +: LANE_W];
            end
            OP_AND:    res_next = s1_a & s1_b;
            OP_OR:     res_next = s1_a | s1_b;
            OP_MIXCOL: res_next = mix_res;
`ifdef SIMD_INV_MIXCOL_EN
            OP_INVMIXCOL: res_next = mix_res;
`endif
            default:   err_next = 1'b1;
        endcase
    end

    // Result registers only load on a real beat, so a stalled output holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_res  <= '0;
            out_err  <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_res <= res_next;
                out_err <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_simd_vec_alu_pipe.sv
// Self-checking bench for simd_vec_alu_pipe: directed steps with a scoreboard queue.
module tb_simd_vec_alu_pipe;

    localparam int NWORDS = 4;
    localparam int W      = 32 * NWORDS;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic [2:0]   in_op     = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_res;
    logic         out_err;

    typedef struct packed {
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           n_checks   = 0;
    int           n_fail     = 0;
    int           inflight   = 0;
    bit           bp_mode    = 1'b0;
    int           bp_idx     = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_res   = '0;
    logic         prev_err   = 1'b0;

    simd_vec_alu_pipe #(.NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference for the byte-lane opcodes.
    function automatic logic [W-1:0] lane_model(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [7:0]   x;
        logic [7:0]   y;
        r = '0;
        for (int i = 0; i < W / 8; i++) begin
            x = a[i*8 +: 8];
            y = b[i*8 +: 8];
            case (op)
                3'd0:    r[i*8 +: 8] = x ^ y;
                3'd1:    r[i*8 +: 8] = x + y;
                3'd2:    r[i*8 +: 8] = x - y;
                3'd3:    r[i*8 +: 8] = x & y;
                3'd4:    r[i*8 +: 8] = x | y;
                default: r[i*8 +: 8] = 8'h00;
            endcase
        end
        return r;
    endfunction

    // Consumer side: out_ready pattern 1,0,0,1 repeating while bp_mode is set.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = !((bp_idx % 4) == 1 || (bp_idx % 4) == 2);
            bp_idx++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            inflight   = 0;
            prev_stall = 1'b0;
        end else begin
            chk_bit("in_ready", in_ready, !(inflight >= 2 && !out_ready));
            if (prev_stall) begin
                chk_vec("hold_res", out_res, prev_res);
                chk_bit("hold_err", out_err, prev_err);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk_int("unexpected_beat_sb_size", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk_vec("res", out_res, e.res);
                    chk_bit("err", out_err, e.err);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_res;
            prev_err   = out_err;
            inflight   = inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic [W-1:0] exp_res, input logic exp_err);
        exp_t e;
        int   budget;
        bit   taken;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        e.res    = exp_res;
        e.err    = exp_err;
        budget   = 0;
        taken    = 1'b0;
        while (!taken && budget <= 50) begin
            @(negedge clk);
            if (in_ready) taken = 1'b1;
            else budget++;
        end
        if (taken) sb.push_back(e);
        else chk_int("send_timeout_cycles", budget, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        in_valid = 1'b0;
        budget   = 0;
        while ((sb.size() != 0 || out_valid) && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk_int("drain_left", sb.size(), 0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] inv_exp;
        logic         inv_err;

        // Reset state
        #1;
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_vec("rst_out_res", out_res, '0);
        chk_bit("rst_out_err", out_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_bit("in_ready_after_reset", in_ready, 1'b1);

        // 1: ADD without inter-lane carry, latency 2
        send({16{8'hFF}}, {16{8'h01}}, 3'b001, '0, 1'b0);
        in_valid = 1'b0;
        chk_bit("lat_after_accept", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk_bit("lat_second_edge", out_valid, 1'b1);
        chk_vec("add_wrap_direct", out_res, '0);
        drain();

        // Lane ops: SUB borrow discarded, then AND / OR / mixed
        send('0, {16{8'h01}}, 3'b010, {16{8'hFF}}, 1'b0);
        send({4{32'h80FF_7F01}}, {4{32'h8001_8002}}, 3'b001, {4{32'h0000_FF03}}, 1'b0);
        send({4{32'h0102_0304}}, {4{32'h0203_0405}}, 3'b010, {4{32'hFFFF_FFFF}}, 1'b0);
        send({4{32'hF0F0_AA55}}, {4{32'h3C3C_FF00}}, 3'b011, {4{32'h3030_AA00}}, 1'b0);
        send({4{32'hF0F0_AA55}}, {4{32'h3C3C_FF00}}, 3'b100, {4{32'hFCFC_FF55}}, 1'b0);
        drain();

        // 2: MixColumns, including a mixed-word vector
        send({4{32'hDB13_5345}}, '0, 3'b101, {4{32'hBCA1_4D8E}}, 1'b0);
        send({4{32'h0101_0101}}, {4{32'hFFFF_FFFF}}, 3'b101, {4{32'h0101_0101}}, 1'b0);
        send({32'hF20A_225C, 32'h0101_0101, 32'hDB13_5345, 32'hD4D4_D4D5}, '0, 3'b101,
             {32'h9D58_DC9F, 32'h0101_0101, 32'hBCA1_4D8E, 32'hD6D7_D5D5}, 1'b0);
        drain();

        // 3: InvMixColumns, legal only when the macro is defined
`ifdef SIMD_INV_MIXCOL_EN
        inv_exp = {32'h4553_13DB, 32'h5C22_0AF2, 32'h4553_13DB, 32'h5C22_0AF2};
        inv_err = 1'b0;
`else
        inv_exp = '0;
        inv_err = 1'b1;
`endif
        send({32'h8E4D_A1BC, 32'h9FDC_589D, 32'h8E4D_A1BC, 32'h9FDC_589D}, '0, 3'b110,
             inv_exp, inv_err);
        drain();

        // 5: illegal opcode between two legal beats
        send({4{32'h1122_3344}}, {4{32'h0F0F_0F0F}}, 3'b000, {4{32'h1E2D_3C4B}}, 1'b0);
        send({4{32'h1234_5678}}, {4{32'h9ABC_DEF0}}, 3'b111, '0, 1'b1);
        send({4{32'h1010_1010}}, {4{32'h0101_0101}}, 3'b001, {4{32'h1111_1111}}, 1'b0);
        drain();

        // 4: backpressure stream of XOR beats
        bp_mode = 1'b1;
        bp_idx  = 0;
        for (int i = 0; i < 8; i++) begin
            a = {16{8'(i)}};
            send(a, {16{8'hA5}}, 3'b000, a ^ {16{8'hA5}}, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            a  = {$urandom(), $urandom(), $urandom(), $urandom()};
            b  = {$urandom(), $urandom(), $urandom(), $urandom()};
            op = 3'($urandom_range(0, 4));
            send(a, b, op, lane_model(op, a, b), 1'b0);
        end
        drain();
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        // 6: asynchronous reset with two beats in flight
        send({4{32'hAAAA_AAAA}}, {4{32'h0000_00FF}}, 3'b000, {4{32'hAAAA_AA55}}, 1'b0);
        send({4{32'h5555_5555}}, {4{32'h0000_00FF}}, 3'b000, {4{32'h5555_55AA}}, 1'b0);
        in_valid = 1'b0;
        chk_bit("pre_reset_out_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit("async_rst_out_valid", out_valid, 1'b0);
        chk_vec("async_rst_out_res", out_res, '0);
        chk_bit("async_rst_out_err", out_err, 1'b0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send({4{32'h0F0F_0F0F}}, {4{32'h0101_0101}}, 3'b010, {4{32'h0E0E_0E0E}}, 1'b0);
        in_valid = 1'b0;
        chk_bit("post_rst_lat_first", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk_bit("post_rst_lat_second", out_valid, 1'b1);
        drain();

        chk_int("final_sb_size", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
